branch_predict_ctrl: RTL
========================

// Module: branch_predict_ctrl
// PURPOSE
//  Dynamic branch-prediction controller for the pipelined core; sits between Fetch and Execute.
//  Predicts B-type branches in F from a 2-bit saturating-counter BHT and tracks each prediction in an in-flight queue.
//  Resolves each prediction when the branch reaches E: updates the counter, flushes F/D and redirects the PC on mispredict.
// PARAMETERS
//  DATA_WIDTH  32  datapath / PC width
//  IDX_BITS    6   BHT index width; 2**IDX_BITS counters, index = PC[IDX_BITS+1:2]
//  DEPTH       4   in-flight queue entries (power of 2, >=2)
// PORTS
//  clk          in   1           core clock
//  rst_n        in   1           asynchronous reset, active-low
//  InstrF       in   DATA_WIDTH  instruction in Fetch
//  PCF          in   DATA_WIDTH  Fetch PC
//  StallF       in   1           Fetch stalled; no push this cycle
//  FlushQ       in   1           external flush of F/D (jump in E); clears queue
//  BranchE      in   1           B-type branch in Execute; pops queue head
//  ZeroE        in   1           branch outcome in E (1 = taken)
//  PCE          in   DATA_WIDTH  Execute PC
//  PCTargetE    in   DATA_WIDTH  resolved branch target
//  PCBPU        out  DATA_WIDTH  redirect / predicted PC
//  PCBPUSrc     out  1           select PCBPU as next PC
//  flushBranch  out  1           mispredict: flush F and D
//  StallBPU     out  1           queue full with branch in F; hold Fetch
// BEHAVIOUR
//  States (FSM): INIT -> RUN <-> RECOVER.
//  Reset: state=INIT, init counter=0, queue empty (rd/wr ptr=0, count=0); all outputs 0.
//  INIT: one BHT entry per cycle written WNT(01); after 2**IDX_BITS cycles -> RUN. No taken predictions.
//   Branches in INIT are pushed with pred=0; BHT updates are dropped.
//  Prediction (RUN, comb): branch_f = InstrF[6:0]==7'b1100011.
//   If branch_f and count<DEPTH and BHT[idx][1]: PCBPUSrc=1, PCBPU=PCF+{{20{InstrF[31]}},InstrF[7],InstrF[30:25],InstrF[11:8],1'b0}.
//   Push {pred,idx} at clock edge when branch_f && !StallF && count<DEPTH && !mispredict && !FlushQ.
//  Full: branch_f && count==DEPTH -> StallBPU=1, no prediction, no push; released the cycle after a pop.
//  Resolve (BranchE): pop head. mispredict = head.pred != ZeroE.
//   Counter update at edge: taken -> sat-inc (max 11), not taken -> sat-dec (min 00), at head.idx.
//   Empty-queue pop (protocol error): treat as pred=0, idx=PCE[IDX_BITS+1:2]; no underflow, count stays 0.
//  Mispredict (comb, same cycle as BranchE): flushBranch=1, PCBPUSrc=1, PCBPU = ZeroE ? PCTargetE : PCE+4.
//   Overrides any F prediction. At the edge: queue cleared (younger entries are wrong-path) and -> RECOVER.
//  RECOVER: one cycle; F holds the redirect target, so predictions are allowed and pushes are normal; -> RUN.
//   Its purpose is to block a second mispredict: BranchE in RECOVER is ignored (flushed bubble).
//  FlushQ: queue cleared at the edge. If a pop and FlushQ occur together, the BHT update still applies.
//  Push+pop same cycle: count unchanged; both pointers advance modulo DEPTH.
//  Mid-operation reset: returns to INIT and re-sweeps the BHT; the queue is discarded.
//  Arithmetic: target adds wrap modulo 2**DATA_WIDTH; pointers are clog2(DEPTH) bits; count is clog2(DEPTH)+1 bits.
// CONFIGURATION
//  BPU_STATS_EN defined: adds outputs BranchCnt[31:0] and MispredCnt[31:0].
//   BranchCnt increments on each resolved pop; MispredCnt increments on each mispredict.
//   Both reset to 0 and wrap at 2**32; neither increments in INIT.
//  Undefined: these ports and their counters do not exist.
// STRUCTURE
//  Package bpu_pkg holds:
//   - OPCODE_BRANCH = 7'b1100011
//   - bht_cnt_t enum: SNT=00, WNT=01, WT=10, ST=11
//   - bpu_state_t enum: INIT, RUN, RECOVER
//   - inflight_t struct: {logic pred; logic [IDX_BITS-1:0] idx}
//  Sub-module bpu_inflight_fifo holds the DEPTH-entry queue (push/pop/clear, count/full/empty).
//  BHT array, FSM and redirect mux stay in branch_predict_ctrl.
// TESTING
//  1. Reset, IDX_BITS=6: 64 INIT cycles with PCBPUSrc=0 on branch fetch -> RUN on cycle 65; all entries read 01.
//  2. BEQ @PCF=0x100, imm=+16, BHT=WT -> PCBPUSrc=1, PCBPU=0x110; BranchE,ZeroE=1 two cycles later -> no flush, entry goes to ST.
//  3. Predicted taken, ZeroE=0, PCE=0x100 -> flushBranch=1, PCBPU=0x104 same cycle; queue count=0; counter WT->WNT.
//  4. Predicted not-taken (WNT), ZeroE=1, PCTargetE=0x80 -> flushBranch=1, PCBPU=0x80; counter -> WT.
//  5. Fill DEPTH=4 with StallF=0, 5th branch in F -> StallBPU=1, no push; one BranchE pop -> StallBPU=0 next cycle.
//  6. Push and FlushQ in the same cycle -> queue empty, no push; BranchE on empty queue -> no underflow, prediction taken as not-taken.

Source files
------------

// File: rtl/bpu_pkg.sv
// Shared types and constants for the branch-prediction controller:
// opcode match value, BHT counter encoding, FSM states and in-flight queue entry.
package bpu_pkg;

    localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;

    // Width of the BHT index carried in each in-flight entry.
    localparam int BHT_IDX_BITS = 6;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } bht_cnt_t;

    typedef enum logic [1:0] {
        INIT    = 2'd0,
        RUN     = 2'd1,
        RECOVER = 2'd2
    } bpu_state_t;

    typedef struct packed {
        logic                    pred;
        logic [BHT_IDX_BITS-1:0] idx;
    } inflight_t;

    function automatic bht_cnt_t bhtNext(input bht_cnt_t cur, input logic taken);
        bht_cnt_t nxt;
        nxt = cur;
        if (taken) begin
            if (cur != ST) nxt = bht_cnt_t'(cur + 2'd1);
        end else begin
            if (cur != SNT) nxt = bht_cnt_t'(cur - 2'd1);
        end
        return nxt;
    endfunction

endpackage

// File: rtl/bpu_inflight_fifo.sv
// DEPTH-entry queue of outstanding predictions, oldest at the head.
// Clear has priority over push/pop; pops on an empty queue are ignored.
module bpu_inflight_fifo
    import bpu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic                     i_clear,
    input  inflight_t                i_wdata,
    output inflight_t                o_rdata,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    inflight_t         r_mem [DEPTH];
    logic [PW-1:0]     r_wrPtr;
    logic [PW-1:0]     r_rdPtr;
    logic [CW-1:0]     r_count;
    logic              w_doPush;
    logic              w_doPop;

    assign o_full   = (r_count == FULL_CNT);
    assign o_empty  = (r_count == '0);
    assign o_count  = r_count;
    assign o_rdata  = r_mem[r_rdPtr];
    assign w_doPush = i_push && !o_full;
    assign w_doPop  = i_pop && !o_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else if (i_clear) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_doPush) r_wrPtr <= r_wrPtr + PW'(1);
            if (w_doPop)  r_rdPtr <= r_rdPtr + PW'(1);
            case ({w_doPush, w_doPop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: only slots between the pointers are ever read.
    always_ff @(posedge clk) begin
        if (w_doPush && !i_clear) r_mem[r_wrPtr] <= i_wdata;
    end

endmodule

// File: rtl/branch_predict_ctrl.sv
// Dynamic branch predictor: 2-bit BHT lookup in Fetch, resolution and redirect in Execute.
// Optional BPU_STATS_EN adds BranchCnt/MispredCnt statistics outputs.
module branch_predict_ctrl
    import bpu_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int IDX_BITS   = BHT_IDX_BITS,
    parameter int DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] InstrF,
    input  logic [DATA_WIDTH-1:0] PCF,
    input  logic                  StallF,
    input  logic                  FlushQ,
    input  logic                  BranchE,
    input  logic                  ZeroE,
    input  logic [DATA_WIDTH-1:0] PCE,
    input  logic [DATA_WIDTH-1:0] PCTargetE,
    output logic [DATA_WIDTH-1:0] PCBPU,
    output logic                  PCBPUSrc,
    output logic                  flushBranch,
    output logic                  StallBPU
`ifdef BPU_STATS_EN
    ,
    output logic [31:0]           BranchCnt,
    output logic [31:0]           MispredCnt
`endif
);

    localparam int BHT_SIZE = 1 << IDX_BITS;

    bpu_state_t              r_state;
    logic [IDX_BITS-1:0]     r_initIdx;
    bht_cnt_t                r_bht [BHT_SIZE];

    logic                    w_branchF;
    logic [IDX_BITS-1:0]     w_idxF;
    logic [IDX_BITS-1:0]     w_idxE;
    logic [DATA_WIDTH-1:0]   w_immB;
    logic                    w_bhtTaken;
    logic                    w_predTaken;
    logic                    w_resolve;
    logic                    w_mispredict;
    logic                    w_push;
    logic                    w_clear;
    logic                    w_bhtUpdate;
    inflight_t               w_pushEntry;
    inflight_t               w_qHead;
    inflight_t               w_head;
    logic [$clog2(DEPTH):0]  w_qCount;
    logic                    w_qFull;
    logic                    w_qEmpty;
    logic                    w_unused;

    assign w_branchF   = (InstrF[6:0] == OPCODE_BRANCH);
    assign w_idxF      = PCF[IDX_BITS+1:2];
    assign w_idxE      = PCE[IDX_BITS+1:2];
    assign w_immB      = {{(DATA_WIDTH-12){InstrF[31]}}, InstrF[7], InstrF[30:25], InstrF[11:8], 1'b0};
    assign w_bhtTaken  = r_bht[w_idxF][1];
    assign w_predTaken = w_branchF && !w_qFull && (r_state != INIT) && w_bhtTaken;

    // RECOVER's E stage holds a flushed bubble, so a BranchE there is not real.
    assign w_resolve    = BranchE && (r_state != RECOVER);
    assign w_mispredict = w_resolve && (w_head.pred != ZeroE);
    assign w_push       = w_branchF && !StallF && !w_qFull && !w_mispredict && !FlushQ;
    assign w_clear      = w_mispredict || FlushQ;
    assign w_bhtUpdate  = w_resolve && (r_state == RUN);

    assign w_pushEntry.pred = w_predTaken;
    assign w_pushEntry.idx  = w_idxF;

    // A resolve with nothing queued falls back to a not-taken guess at the E-stage index.
    always_comb begin
        w_head = w_qHead;
        if (w_qEmpty) begin
            w_head.pred = 1'b0;
            w_head.idx  = w_idxE;
        end
    end

    bpu_inflight_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_pop   (w_resolve),
        .i_clear (w_clear),
        .i_wdata (w_pushEntry),
        .o_rdata (w_qHead),
        .o_count (w_qCount),
        .o_full  (w_qFull),
        .o_empty (w_qEmpty)
    );

    always_comb begin
        PCBPU    = '0;
        PCBPUSrc = 1'b0;
        if (w_mispredict) begin
            PCBPUSrc = 1'b1;
            PCBPU    = ZeroE ? PCTargetE : (PCE + DATA_WIDTH'(4));
        end else if (w_predTaken) begin
            PCBPUSrc = 1'b1;
            PCBPU    = PCF + w_immB;
        end
    end

    assign flushBranch = w_mispredict;
    assign StallBPU    = w_branchF && w_qFull;

    // The table has no reset of its own; INIT rewrites every entry after each reset.
    always_ff @(posedge clk) begin
        if (r_state == INIT) begin
            r_bht[r_initIdx] <= WNT;
        end else if (w_bhtUpdate) begin
            r_bht[w_head.idx] <= bhtNext(r_bht[w_head.idx], ZeroE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= INIT;
            r_initIdx <= '0;
        end else begin
            case (r_state)
                INIT: begin
                    r_initIdx <= r_initIdx + IDX_BITS'(1);
                    if (r_initIdx == '1) r_state <= RUN;
                end
                RUN:     if (w_mispredict) r_state <= RECOVER;
                RECOVER: r_state <= RUN;
                default: r_state <= INIT;
            endcase
        end
    end

`ifdef BPU_STATS_EN
    logic [31:0] r_branchCnt;
    logic [31:0] r_mispredCnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_branchCnt  <= '0;
            r_mispredCnt <= '0;
        end else if (r_state == RUN) begin
            if (w_resolve)    r_branchCnt  <= r_branchCnt + 32'd1;
            if (w_mispredict) r_mispredCnt <= r_mispredCnt + 32'd1;
        end
    end

    assign BranchCnt  = r_branchCnt;
    assign MispredCnt = r_mispredCnt;
`endif

    assign w_unused = ^{InstrF[24:12], w_qCount};

endmodule
